b2bcd_seq: RTL

Sequential, parametrised binary-to-BCD converter using iterative shift-add-3 (double dabble). It processes one input bit per clock and uses valid/ready handshakes on both sides. Optional two's-complement input mode and an overflow flag make it the multi-cycle, area-lean successor to the team's combinational divide/modulo converter. It sits between arithmetic datapaths and display or serial output logic, where many-bit combinational division is too costly.

---
 rtl/b2bcd_pkg.sv | 17 +
 rtl/b2bcd_seq_digit.sv | 30 +++
 rtl/b2bcd_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/b2bcd_pkg.sv
// Shared constants and helpers for the sequential binary-to-BCD converter.
package b2bcd_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Bits per BCD digit
  localparam int DIGIT_W = 4;

  // Double-dabble correction: a digit of 5 or more gets 3 added before the shift
  function automatic logic [3:0] add3_adj(input logic [3:0] d);
    return (d >= 4'd5) ? 4'(d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/b2bcd_seq_digit.sv
// One BCD digit of the shift-add-3 chain. The digit value it would take on
// the next shift and the bit it passes to the next digit are both exposed.
module bcd_digit_cell
  import b2bcd_pkg::*;
(
  input  logic               clk,
  input  logic               i_clr,
  input  logic               i_shift_en,
  input  logic               i_shift_in,
  output logic [DIGIT_W-1:0] o_digit_nxt,
  output logic               o_shift_out
);

  logic [DIGIT_W-1:0] r_digit;
  logic [DIGIT_W-1:0] w_adj;

  assign w_adj       = add3_adj(r_digit);
  assign o_shift_out = w_adj[DIGIT_W-1];
  assign o_digit_nxt = {w_adj[DIGIT_W-2:0], i_shift_in};

  // Scratch digit: cleared on load, adjusted and shifted each SHIFT cycle
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_digit <= '0;
    end else if (i_shift_en) begin
      r_digit <= o_digit_nxt;
    end
  end

endmodule

// File: rtl/b2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock,
// valid/ready on both sides, optional two's-complement input.
module b2bcd_seq
  import b2bcd_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DIGIT     = 5,
  parameter int SIGNED_IN = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         Binary_code,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DIGIT*DIGIT_W-1:0] BCD_code,
  output logic                     BCD_sign,
  output logic                     BCD_ovf
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]               r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic [WIDTH-1:0]         r_mag;
  logic                     r_sign;
  logic                     r_ovf;
  logic                     w_accept;
  logic                     w_shift;
  logic                     w_last;
  logic                     w_neg;
  logic [WIDTH-1:0]         w_mag_load;
  logic [DIGIT:0]           w_chain;
  logic [DIGIT*DIGIT_W-1:0] w_bcd_next;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid & in_ready;
  assign w_shift   = (r_state == SHIFT);
  assign w_last    = w_shift & (r_cnt == LAST_CNT);

  // Most negative input negates to 2^(WIDTH-1), which still fits unsigned
  assign w_neg      = (SIGNED_IN != 0) & Binary_code[WIDTH-1];
  assign w_mag_load = w_neg ? (-Binary_code) : Binary_code;

  // Magnitude MSB feeds digit 0; each digit feeds the next; the top digit's
  // carry-out is the overflow bit.
  assign w_chain[0] = r_mag[WIDTH-1];

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk         (clk),
      .i_clr       (w_accept),
      .i_shift_en  (w_shift),
      .i_shift_in  (w_chain[gi]),
      .o_digit_nxt (w_bcd_next[gi*DIGIT_W +: DIGIT_W]),
      .o_shift_out (w_chain[gi+1])
    );
  end

  // Control FSM with bit counter, sign latch and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sign  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_state <= SHIFT;
            r_cnt   <= '0;
            r_sign  <= w_neg;
            r_ovf   <= 1'b0;
          end
        end
        SHIFT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          r_ovf <= r_ovf | w_chain[DIGIT];
          if (w_last) begin
            r_state <= DONE;
            r_cnt   <= '0;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Magnitude register: loaded on accept, shifted into the digit chain
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mag <= w_mag_load;
    end else if (w_shift) begin
      r_mag <= {r_mag[WIDTH-2:0], 1'b0};
    end
  end

  // Result registers: capture the final shift so outputs only change entering DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      BCD_code <= '0;
      BCD_sign <= 1'b0;
      BCD_ovf  <= 1'b0;
    end else if (w_last) begin
      BCD_code <= w_bcd_next;
      BCD_sign <= r_sign;
      BCD_ovf  <= r_ovf | w_chain[DIGIT];
    end
  end

endmodule
